// File: rtl/gpio_entrada.sv
// Memory-mapped GPIO input block: synchronized, debounced pins with
// rising-edge capture (write-1-to-clear), interrupt mask and a level irq.
module gpio_entrada #(
    parameter logic [31:0] BASE       = 32'h0000_0800,
    parameter int          N_PINS     = 8,
    parameter int          DEB_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [N_PINS-1:0] pines,
    input  logic [31:0]       direccion,
    input  logic [31:0]       datos,
    input  logic              we,
    input  logic              re,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              irq
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [N_PINS-1:0] meta_p0;
    logic [N_PINS-1:0] sync_p1;
    logic [CNT_W-1:0]  cnt_p2 [N_PINS];
    logic [N_PINS-1:0] stable_p2;
    logic [N_PINS-1:0] flanco;
    logic [N_PINS-1:0] mascara;

    logic              hit;
    logic [1:0]        offset;
    logic              wr_flanco;
    logic              wr_mascara;
    logic              rd_hit;
    logic [N_PINS-1:0] accept;
    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] clr;
    logic [N_PINS-1:0] flanco_next;
    logic [31:0]       rd_word;
    logic              unused_addr_bits;

    assign hit        = (direccion[31:4] == BASE[31:4]);
    assign offset     = direccion[3:2];
    assign wr_flanco  = we && hit && (offset == 2'd1);
    assign wr_mascara = we && hit && (offset == 2'd2);
    assign rd_hit     = re && hit;
    assign unused_addr_bits = ^{direccion[1:0], datos};

    // Stage p0/p1: two-flop synchronizer for the asynchronous pins
    always_ff @(posedge CLK) begin
        if (rst) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            meta_p0 <= pines;
            sync_p1 <= meta_p0;
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < N_PINS; i++) begin
            accept[i] = (sync_p1[i] != stable_p2[i]) && (cnt_p2[i] == CNT_LAST);
        end
    end

    assign rise        = accept & sync_p1;
    assign clr         = wr_flanco ? datos[N_PINS-1:0] : '0;
    // A rising edge landing in the same cycle as a clear must not be lost
    assign flanco_next = (flanco & ~clr) | rise;

    // Stage p2: per-pin debounce counters and accepted level
    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < N_PINS; i++) begin
                cnt_p2[i] <= '0;
            end
            stable_p2 <= '0;
        end else begin
            for (int i = 0; i < N_PINS; i++) begin
                if ((sync_p1[i] == stable_p2[i]) || accept[i]) begin
                    cnt_p2[i] <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + 1'b1;
                end
            end
            stable_p2 <= stable_p2 ^ accept;
        end
    end

    always_comb begin
        rd_word = '0;
        case (offset)
            2'd0:    rd_word = 32'(stable_p2);
            2'd1:    rd_word = 32'(flanco);
            2'd2:    rd_word = 32'(mascara);
            default: rd_word = 32'(sync_p1);
        endcase
    end

    // Register file and load port; reads see the value before any same-cycle write
    always_ff @(posedge CLK) begin
        if (rst) begin
            flanco  <= '0;
            mascara <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
        end else begin
            flanco <= flanco_next;
            if (wr_mascara) begin
                mascara <= datos[N_PINS-1:0];
            end
            rvalid <= rd_hit;
            if (rd_hit) begin
                rdata <= rd_word;
            end
        end
    end

    assign irq = |(flanco & mascara);

endmodule

// File: tb/tb_gpio_entrada.sv
// Directed bench for gpio_entrada: register-access vector table plus
// hand-timed debounce, edge-capture, interrupt and reset sequences.
module tb_gpio_entrada;

    localparam logic [31:0] BASE = 32'h0000_0800;

    logic        CLK;
    logic        rst;
    logic [7:0]  pines;
    logic [31:0] direccion;
    logic [31:0] datos;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        re;
        logic [31:0] d;
        logic        exp_rv;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[13];

    gpio_entrada #(.BASE(BASE), .N_PINS(8), .DEB_CYCLES(16)) dut (
        .CLK(CLK), .rst(rst), .pines(pines), .direccion(direccion), .datos(datos),
        .we(we), .re(re), .rdata(rdata), .rvalid(rvalid), .irq(irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d);
        direccion = addr;
        datos     = d;
        we        = 1'b1;
        tick();
        we        = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        direccion = addr;
        re        = 1'b1;
        tick();
        re        = 1'b0;
        check({name, "_rvalid"}, {31'b0, rvalid}, 32'h1);
        check(name, rdata, exp);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        pines     = '0;
        direccion = '0;
        datos     = '0;
        we        = 1'b0;
        re        = 1'b0;

        //          addr          we    re    datos         rv    rdata
        tbl[0]  = '{32'h0000_0808, 1'b1, 1'b0, 32'hFFFF_FFA5, 1'b0, 32'h0};
        tbl[1]  = '{32'h0000_0808, 1'b0, 1'b1, 32'h0,         1'b1, 32'hA5};
        tbl[2]  = '{32'h0000_0808, 1'b1, 1'b1, 32'h3C,        1'b1, 32'hA5};
        tbl[3]  = '{32'h0000_080B, 1'b0, 1'b1, 32'h0,         1'b1, 32'h3C};
        tbl[4]  = '{32'h0000_0810, 1'b0, 1'b1, 32'h0,         1'b0, 32'h3C};
        tbl[5]  = '{32'h0000_0818, 1'b1, 1'b0, 32'h0,         1'b0, 32'h3C};
        tbl[6]  = '{32'h0000_0808, 1'b0, 1'b1, 32'h0,         1'b1, 32'h3C};
        tbl[7]  = '{32'h0000_0800, 1'b1, 1'b0, 32'hFF,        1'b0, 32'h3C};
        tbl[8]  = '{32'h0000_0800, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
        tbl[9]  = '{32'h0000_080C, 1'b1, 1'b0, 32'hFF,        1'b0, 32'h0};
        tbl[10] = '{32'h0000_080C, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
        tbl[11] = '{32'h0000_0804, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0};
        tbl[12] = '{32'h0000_0004, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0};

        tick();
        tick();
        check("reset_rdata", rdata, 32'h0);
        check("reset_rvalid", {31'b0, rvalid}, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            direccion = tbl[i].addr;
            we        = tbl[i].we;
            re        = tbl[i].re;
            datos     = tbl[i].d;
            tick();
            check($sformatf("vec%0d_rvalid", i), {31'b0, rvalid}, {31'b0, tbl[i].exp_rv});
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, 32'h0);
        end
        we = 1'b0;
        re = 1'b0;

        // Pin 0 rises: accepted on the 18th edge, observed through irq and DATO reads
        wr(BASE + 32'h8, 32'h1);
        pines     = 8'h01;
        direccion = BASE;
        re        = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 17) check("deb_irq_e17", {31'b0, irq}, 32'h0);
            if (k == 18) begin
                check("deb_irq_e18", {31'b0, irq}, 32'h1);
                check("deb_dato_pre_e18", rdata, 32'h0);
            end
            if (k == 19) begin
                check("deb_dato_e19", rdata, 32'h1);
                check("deb_rvalid_e19", {31'b0, rvalid}, 32'h1);
            end
        end
        re = 1'b0;
        rd(BASE + 32'h4, 32'h1, "flanco_set");
        rd(BASE + 32'hC, 32'h1, "crudo_high");
        wr(BASE + 32'h4, 32'h0);
        check("w1c_zero_irq", {31'b0, irq}, 32'h1);
        wr(BASE + 32'h4, 32'h1);
        check("w1c_one_irq", {31'b0, irq}, 32'h0);
        rd(BASE + 32'h4, 32'h0, "flanco_cleared");

        // Short 10-cycle pulse on pin 1: visible on CRUDO, rejected by debounce
        direccion = BASE + 32'hC;
        re        = 1'b1;
        pines     = 8'h03;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 10) pines = 8'h01;
            if (k == 2)  check("crudo_k2", rdata, 32'h01);
            if (k == 3)  check("crudo_k3", rdata, 32'h03);
            if (k == 12) check("crudo_k12", rdata, 32'h03);
            if (k == 13) check("crudo_k13", rdata, 32'h01);
        end
        re = 1'b0;
        repeat (25) tick();
        rd(BASE, 32'h01, "glitch_dato");
        rd(BASE + 32'h4, 32'h0, "glitch_flanco");
        check("glitch_irq", {31'b0, irq}, 32'h0);

        // Clear of bit 2 lands on the same edge that sets it
        pines = 8'h05;
        repeat (17) tick();
        direccion = BASE + 32'h4;
        datos     = 32'h4;
        we        = 1'b1;
        tick();
        we = 1'b0;
        rd(BASE + 32'h4, 32'h4, "w1c_vs_set");
        check("masked_irq", {31'b0, irq}, 32'h0);
        wr(BASE + 32'h8, 32'h4);
        check("unmasked_irq", {31'b0, irq}, 32'h1);

        // Reset in the middle of a debounce with pin 0 held high
        pines = 8'h00;
        repeat (25) tick();
        rd(BASE + 32'h8, 32'h4, "pre_reset_mascara");
        check("pre_reset_irq", {31'b0, irq}, 32'h1);
        pines = 8'h01;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        check("mid_reset_rdata", rdata, 32'h0);
        check("mid_reset_rvalid", {31'b0, rvalid}, 32'h0);
        check("mid_reset_irq", {31'b0, irq}, 32'h0);
        rst = 1'b0;
        wr(BASE + 32'h8, 32'h1);
        repeat (16) tick();
        check("post_reset_irq_e17", {31'b0, irq}, 32'h0);
        tick();
        check("post_reset_irq_e18", {31'b0, irq}, 32'h1);
        rd(BASE, 32'h1, "post_reset_dato");
        rd(BASE + 32'h4, 32'h1, "post_reset_flanco");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
